// File: rtl/sel_hold_mux_n.sv
// sel_hold_mux_n: N-channel, WIDTH-bit registered select-and-hold multiplexer.
// The output is held in a flop while no select is asserted. Fixed-priority or
// round-robin arbitration picks the winner. A conflict flag, the winner index
// and an age counter are exported for hazard and debug logic.
module sel_hold_mux_n #(
    parameter int              WIDTH     = 8,
    parameter int              N         = 3,
    parameter int              MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              AGE_W     = 4,
    localparam int             IW        = (N > 2) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       sel,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic [IW-1:0]      sel_idx,
    output logic               conflict,
    output logic               hold,
    output logic [AGE_W-1:0]   age
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win;
    logic [WIDTH-1:0] win_data;
    logic             any_sel;
    logic             multi_sel;
    logic [IW-1:0]    rr_next;

    // Winner search: lowest index in MODE 0, first asserted from rr_ptr upward in MODE 1.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        win      = '0;
        win_data = data_in[WIDTH-1:0];
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (MODE == 1) ? int'(rr_ptr) + k : k;
            if (j >= N) j = j - N;
            // Scanning from the far end downward lets the nearest hit overwrite the rest.
            if (sel[j]) begin
                win      = IW'(j);
                win_data = data_in[j*WIDTH +: WIDTH];
            end
        end
        any_sel   = |sel;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi_sel = |(sel & (sel - N'(1)));
        rr_next   = (win == LAST_IDX) ? '0 : win + IW'(1);
    end

    // Output, status and arbitration-pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            out       <= RESET_VAL;
            out_valid <= 1'b0;
            sel_idx   <= '0;
            conflict  <= 1'b0;
            hold      <= 1'b0;
            age       <= '0;
            rr_ptr    <= '0;
        end else if (any_sel) begin
            out       <= win_data;
            out_valid <= 1'b1;
            sel_idx   <= win;
            conflict  <= multi_sel;
            hold      <= 1'b0;
            age       <= '0;
            if (MODE == 1) rr_ptr <= rr_next;
        end else begin
            hold     <= 1'b1;
            conflict <= 1'b0;
            if (age != '1) age <= age + AGE_W'(1);
        end
    end

endmodule

// File: tb/tb_sel_hold_mux_n.sv
// tb_sel_hold_mux_n: directed self-checking bench for sel_hold_mux_n.
// One fixed-priority instance (RESET_VAL 8'h5A) and one round-robin instance
// share clock and reset; each has its own data and select inputs.
module tb_sel_hold_mux_n;

    localparam int WIDTH = 8;
    localparam int N     = 3;
    localparam int AGE_W = 4;
    localparam int IW    = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [N*WIDTH-1:0] data_p, data_r;
    logic [N-1:0]       sel_p, sel_r;
    logic [WIDTH-1:0]   out_p, out_r;
    logic               valid_p, valid_r, conf_p, conf_r, hold_p, hold_r;
    logic [IW-1:0]      idx_p, idx_r;
    logic [AGE_W-1:0]   age_p, age_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sel_hold_mux_n #(.WIDTH(WIDTH), .N(N), .MODE(0), .RESET_VAL(8'h5A), .AGE_W(AGE_W)) u_prio (
        .clk(clk), .rst_n(rst_n), .data_in(data_p), .sel(sel_p), .out(out_p),
        .out_valid(valid_p), .sel_idx(idx_p), .conflict(conf_p), .hold(hold_p), .age(age_p)
    );

    sel_hold_mux_n #(.WIDTH(WIDTH), .N(N), .MODE(1), .RESET_VAL(8'hA5), .AGE_W(AGE_W)) u_rr (
        .clk(clk), .rst_n(rst_n), .data_in(data_r), .sel(sel_r), .out(out_r),
        .out_valid(valid_r), .sel_idx(idx_r), .conflict(conf_r), .hold(hold_r), .age(age_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_grant(input logic [N-1:0] s, input logic [IW-1:0] exp_idx,
                            input logic [WIDTH-1:0] exp_out, input logic exp_conf);
        sel_r = s;
        tick();
        check("rr_idx", 32'(idx_r), 32'(exp_idx));
        check("rr_out", 32'(out_r), 32'(exp_out));
        check("rr_conflict", 32'(conf_r), 32'(exp_conf));
    endtask

    initial begin
        rst_n  = 1'b0;
        data_p = '0;
        data_r = '0;
        sel_p  = '0;
        sel_r  = '0;

        // Reset held for two cycles.
        tick();
        tick();
        check("rst_out", 32'(out_p), 32'h5A);
        check("rst_valid", 32'(valid_p), 0);
        check("rst_age", 32'(age_p), 0);
        check("rst_hold", 32'(hold_p), 0);
        check("rst_idx", 32'(idx_p), 0);
        check("rst_conflict", 32'(conf_p), 0);
        check("rst_out_rr", 32'(out_r), 32'hA5);

        // Fixed priority: two selects, lowest index wins.
        rst_n  = 1'b1;
        data_p = {8'h33, 8'h22, 8'h11};
        sel_p  = 3'b110;
        tick();
        check("prio_out", 32'(out_p), 32'h22);
        check("prio_idx", 32'(idx_p), 1);
        check("prio_conflict", 32'(conf_p), 1);
        check("prio_valid", 32'(valid_p), 1);
        check("prio_hold", 32'(hold_p), 0);
        check("prio_age", 32'(age_p), 0);

        // Hold for 20 idle cycles; age saturates at 15. Data changes must not leak.
        sel_p  = '0;
        data_p = {8'hEE, 8'hDD, 8'hCC};
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("hold_out", 32'(out_p), 32'h22);
            check("hold_flag", 32'(hold_p), 1);
            check("hold_age", 32'(age_p), (i > 15) ? 15 : i);
            check("hold_conflict", 32'(conf_p), 0);
        end
        check("hold_valid", 32'(valid_p), 1);
        check("hold_idx", 32'(idx_p), 1);

        // Fixed priority never rotates: all selects high twice -> channel 0 both times.
        data_p = {8'h33, 8'h22, 8'h11};
        sel_p  = 3'b111;
        tick();
        check("prio_all_idx0", 32'(idx_p), 0);
        tick();
        check("prio_all_idx1", 32'(idx_p), 0);
        check("prio_all_out", 32'(out_p), 32'h11);

        // Single select on the top channel.
        sel_p = 3'b100;
        tick();
        check("single_out", 32'(out_p), 32'h33);
        check("single_idx", 32'(idx_p), 2);
        check("single_conflict", 32'(conf_p), 0);

        // Load C3 from channel 0, then idle 7 cycles.
        data_p = {8'h77, 8'h66, 8'hC3};
        sel_p  = 3'b001;
        tick();
        check("c3_out", 32'(out_p), 32'hC3);
        sel_p = '0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_age", 32'(age_p), 7);
        check("pre_rst_out", 32'(out_p), 32'hC3);

        // Mid-operation reset overrides an asserted select.
        rst_n  = 1'b0;
        sel_p  = 3'b001;
        data_p = {8'h77, 8'h66, 8'h99};
        tick();
        check("mid_rst_out", 32'(out_p), 32'h5A);
        check("mid_rst_valid", 32'(valid_p), 0);
        check("mid_rst_age", 32'(age_p), 0);
        check("mid_rst_idx", 32'(idx_p), 0);
        rst_n = 1'b1;
        sel_p = '0;

        // Round-robin: all selects for 4 cycles -> 0,1,2,0.
        data_r = {8'h33, 8'h22, 8'h11};
        rr_grant(3'b111, 0, 8'h11, 1'b1);
        rr_grant(3'b111, 1, 8'h22, 1'b1);
        rr_grant(3'b111, 2, 8'h33, 1'b1);
        rr_grant(3'b111, 0, 8'h11, 1'b1);
        // rr_ptr=1: grant 1 moves it to 2; then wrap search from 2 finds 0 -> rr_ptr=1.
        rr_grant(3'b010, 1, 8'h22, 1'b0);
        rr_grant(3'b001, 0, 8'h11, 1'b0);
        // rr_ptr=1 confirmed: search 1,2 on 101 picks 2 -> rr_ptr=0.
        rr_grant(3'b101, 2, 8'h33, 1'b1);
        // Idle leaves rr_ptr at 0.
        sel_r = '0;
        tick();
        check("rr_idle_hold", 32'(hold_r), 1);
        check("rr_idle_out", 32'(out_r), 32'h33);
        rr_grant(3'b011, 0, 8'h11, 1'b1);
        // rr_ptr now 1; a reset must return it to 0 so 011 picks channel 0 again.
        rst_n = 1'b0;
        sel_r = 3'b001;
        tick();
        check("rr_rst_out", 32'(out_r), 32'hA5);
        check("rr_rst_valid", 32'(valid_r), 0);
        rst_n = 1'b1;
        rr_grant(3'b011, 0, 8'h11, 1'b1);
        check("rr_valid", 32'(valid_r), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
